bram_bank_streamer: RTL

Read sequencer feeding the multi-bank read ports of the AXI multi-BRAM controller. On a start command it walks a contiguous range of bank addresses, drives the same address to all M_PORTS banks each cycle, and packs the M_PORTS returned words into one AXI-Stream beat. A 4-entry output FIFO with credit-based issue absorbs the fixed read latency under downstream backpressure. Output goes to the compute datapath.

---
 rtl/bram_bank_streamer_pkg.sv | 21 ++
 rtl/bank_stream_fifo.sv | 54 +++++
 rtl/bram_bank_streamer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bram_bank_streamer_pkg.sv
// Shared definitions for the bank read streamer: FSM states, FIFO geometry
// and the issue-credit test.
package bram_bank_streamer_pkg;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_PTR_W = 2;
   localparam int unsigned FIFO_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A read may issue only if every word already queued or in flight still fits.
   function automatic logic credit_ok(input logic [FIFO_CNT_W-1:0] fill,
                                      input logic [1:0]            inflight);
      return (4'(fill) + 4'(inflight)) < 4'(FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/bank_stream_fifo.sv
// Depth-4 synchronous FIFO holding {last, beat}; slots are cleared on pop so an
// empty FIFO presents all-zero data.
module bank_stream_fifo
   import bram_bank_streamer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic [FIFO_CNT_W-1:0] count,
   output logic                  empty,
   output logic                  full
);

   logic [WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic                  do_pop;
   logic                  do_push;

   assign empty   = (count == '0);
   assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop) begin
            mem[rd_ptr] <= '0;
            rd_ptr      <= rd_ptr + FIFO_PTR_W'(1);
         end
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bram_bank_streamer.sv
// Walks a contiguous bank address range, reads all banks in lockstep and
// streams the packed words out over AXI-Stream with credit-limited issue.
module bram_bank_streamer
   import bram_bank_streamer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned M_PORTS         = 1,
   parameter int unsigned BANK_ADDR_WIDTH = 14,
   parameter int unsigned LEN_WIDTH       = 16
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               start,
   input  logic [BANK_ADDR_WIDTH-1:0]         base_addr,
   input  logic [LEN_WIDTH-1:0]               count,
   output logic                               busy,
   output logic                               done,
   output logic [M_PORTS*BANK_ADDR_WIDTH-1:0] raddr,
   input  logic [M_PORTS*DATA_WIDTH-1:0]      rdata,
   output logic [M_PORTS*DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic                               m_axis_tlast
);

   localparam int unsigned BEAT_W = M_PORTS * DATA_WIDTH;

   state_t                    state;
   state_t                    state_next;
   logic [BANK_ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]       remaining;
   logic                       s1_vld, s1_last, s2_vld, s2_last;
   logic [1:0]                 inflight;

   logic                       issue_c;
   logic                       handshake_c;
   logic [BANK_ADDR_WIDTH-1:0] issue_addr_c;
   logic [LEN_WIDTH-1:0]       issue_rem_c;
   logic                       issue_last_c;

   logic [BEAT_W:0]            fifo_dout;
   logic [FIFO_CNT_W-1:0]      fifo_count;
   logic                       fifo_empty;
   logic                       fifo_full;

   assign inflight      = 2'(s1_vld) + 2'(s2_vld);
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = fifo_dout[BEAT_W-1:0];
   assign m_axis_tlast  = fifo_dout[BEAT_W];
   assign handshake_c   = m_axis_tvalid & m_axis_tready;

   // The first read issues on the accepting edge so raddr shows base one cycle later.
   always_comb begin
      state_next   = state;
      issue_c      = 1'b0;
      issue_addr_c = (state == ST_IDLE) ? base_addr : addr;
      issue_rem_c  = (state == ST_IDLE) ? count : remaining;
      issue_last_c = (issue_rem_c == LEN_WIDTH'(1));
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (count == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
                  issue_c    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            issue_c = (remaining != '0) && credit_ok(fifo_count, inflight);
            if (handshake_c && m_axis_tlast) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         addr      <= '0;
         remaining <= '0;
         raddr     <= '0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s2_vld    <= 1'b0;
         s2_last   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != ST_IDLE);
         done  <= (state_next == ST_DONE);
         if (issue_c) begin
            raddr     <= {M_PORTS{issue_addr_c}};
            addr      <= issue_addr_c + BANK_ADDR_WIDTH'(1);
            remaining <= issue_rem_c - LEN_WIDTH'(1);
         end
         // Two-stage tag tracks the bank's one-cycle read latency plus raddr register.
         s1_vld  <= issue_c;
         s1_last <= issue_c & issue_last_c;
         s2_vld  <= s1_vld;
         s2_last <= s1_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!(s2_vld && fifo_full && !handshake_c))
            else $error("bank_stream_fifo overflow");
      end
   end

   bank_stream_fifo #(
      .WIDTH (BEAT_W + 1)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (s2_vld),
      .din   ({s2_last, rdata}),
      .pop   (m_axis_tready),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
